// File: rtl/msu_pkg.sv
// Shared defaults and state encoding for the MSU
// iteration scheduler.
package msu_pkg;

  localparam int MSU_NUM_ELEMENTS = 66;
  localparam int MSU_BIT_LEN      = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } msu_sched_state_t;

endpackage

// File: rtl/msu_watchdog.sv
// Cycle counter that flags a squarer that has gone
// silent for TIMEOUT consecutive wait cycles.
module msu_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the cycle whose increment reaches TIMEOUT
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/msu_iter_sched.sv
// Sequences repeated squarings of a seed through an
// external squarer, with abort and timeout handling.
module msu_iter_sched
  import msu_pkg::*;
#(
  parameter int NUM_ELEMENTS = MSU_NUM_ELEMENTS,
  parameter int BIT_LEN      = MSU_BIT_LEN,
  parameter int T_LEN        = 64,
  parameter int TIMEOUT      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [T_LEN-1:0]                t_in,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] seed,
  input  logic                            abort,
  output logic                            sq_start,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_data,
  input  logic                            sq_valid,
  input  logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_result,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic                            error,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] result,
  output logic [T_LEN-1:0]                iter_count
);

  localparam int W = NUM_ELEMENTS * BIT_LEN;

  msu_sched_state_t state;

  logic [W-1:0]     operand;
  logic [W-1:0]     result_q;
  logic [T_LEN-1:0] target;
  logic [T_LEN-1:0] cnt;
  logic [T_LEN-1:0] cnt_nxt;
  logic             sq_start_q;
  logic             done_q;
  logic             aborted_q;
  logic             error_q;
  logic             busy_q;
  logic             accept;
  logic             wd_clear;
  logic             wd_en;
  logic             wd_expired;

  assign accept   = start && !abort && (state == S_IDLE);
  assign cnt_nxt  = cnt + T_LEN'(1);
  assign wd_clear = (state == S_ISSUE);
  assign wd_en    = (state == S_WAIT) && !sq_valid && !abort;

  msu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      operand    <= '0;
      result_q   <= '0;
      target     <= '0;
      cnt        <= '0;
      sq_start_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sq_start_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            error_q <= 1'b0;
            cnt     <= '0;
            if (t_in == '0) begin
              result_q <= seed;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              operand    <= seed;
              target     <= t_in;
              sq_start_q <= 1'b1;
              busy_q     <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end else if (sq_valid) begin
            operand <= sq_result;
            cnt     <= cnt_nxt;
            if (cnt_nxt == target) begin
              result_q <= sq_result;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= S_DONE;
            end else begin
              sq_start_q <= 1'b1;
              state      <= S_ISSUE;
            end
          end else if (wd_expired) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_ERROR;
          end
        end
        S_DONE: begin
          aborted_q <= abort;
          state     <= S_IDLE;
        end
        S_ERROR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // An abort landing on the DONE cycle suppresses completion
  assign done       = done_q && !abort;
  assign sq_start   = sq_start_q;
  assign sq_data    = operand;
  assign busy       = busy_q;
  assign aborted    = aborted_q;
  assign error      = error_q;
  assign result     = result_q;
  assign iter_count = cnt;

endmodule
